// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: stall FSM encoding, register-zero constant and
// the PC / IF_ID / ID_EX control bundle driven by the hazard stall controller.
package pipeline_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Control bundles, ordered {pc_write, if_id_write, if_id_flush, id_ex_flush}
  localparam ctrl_t CTRL_NORMAL = 4'b1100;
  localparam ctrl_t CTRL_STALL  = 4'b0001;
  localparam ctrl_t CTRL_JUMP   = 4'b1110;
  localparam ctrl_t CTRL_BRANCH = 4'b1111;
  localparam ctrl_t CTRL_RESET  = 4'b0011;

  // Register $0 is hardwired, so a zero destination never creates a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest);
    return (dest != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use (lu), load-to-early-rs in EX (lb) and
// load-to-early-rs in MEM (mb), the cases ID-stage forwarding cannot cover.
import pipeline_pkg::*;

module hazard_detect (
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_Use_Rs,
  input  logic       ID_Use_Rt,
  input  logic       ID_Early_Rs,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Write_Addr,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_Write_Addr,
  output logic       lu,
  output logic       lb,
  output logic       mb
);

  logic rs_hits_ex;
  logic rt_hits_ex;
  logic rs_hits_mem;

  assign rs_hits_ex  = reg_match(ID_Rs, ID_EX_Write_Addr);
  assign rt_hits_ex  = reg_match(ID_Rt, ID_EX_Write_Addr);
  assign rs_hits_mem = reg_match(ID_Rs, EX_MEM_Write_Addr);

  assign lu = ID_EX_MemRead & ((ID_Use_Rs & rs_hits_ex) | (ID_Use_Rt & rt_hits_ex));
  assign lb = ID_EX_MemRead & ID_Early_Rs & rs_hits_ex;
  assign mb = EX_MEM_MemRead & ID_Early_Rs & rs_hits_mem;

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline around load hazards, taken
// branches and jumps. Optional performance counters: HAZARD_PERF_CNT_EN.
import pipeline_pkg::*;

module hazard_stall_controller #(
  parameter int LD_BR_STALL = 2,
  parameter int PERF_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_Use_Rs,
  input  logic       ID_Use_Rt,
  input  logic       ID_Early_Rs,
  input  logic       ID_Jump,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Write_Addr,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_Write_Addr,
  input  logic       EX_Branch_Taken,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] Stall_Cnt,
  output logic [PERF_W-1:0] Flush_Cnt
`endif
);

  if (LD_BR_STALL < 1 || LD_BR_STALL > 3 || PERF_W < 1) begin : g_bad_param
    $error("hazard_stall_controller: LD_BR_STALL must be 1..3 and PERF_W >= 1");
  end

  localparam logic [1:0] HOLD_LOAD = 2'(LD_BR_STALL - 1);

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  ctrl_t      ctrl;
  logic       lu, lb, mb;

  hazard_detect u_detect (
    .ID_Rs             (ID_Rs),
    .ID_Rt             (ID_Rt),
    .ID_Use_Rs         (ID_Use_Rs),
    .ID_Use_Rt         (ID_Use_Rt),
    .ID_Early_Rs       (ID_Early_Rs),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_Write_Addr  (ID_EX_Write_Addr),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_Write_Addr (EX_MEM_Write_Addr),
    .lu                (lu),
    .lb                (lb),
    .mb                (mb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Priority: reset > taken branch > HOLD > new hazard > jump
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctrl       = CTRL_NORMAL;
    if (!reset) begin
      ctrl       = CTRL_RESET;
      state_next = RUN;
      cnt_next   = 2'd0;
    end else if (EX_Branch_Taken) begin
      ctrl       = CTRL_BRANCH;
      state_next = RUN;
      cnt_next   = 2'd0;
    end else if (state == HOLD) begin
      ctrl = CTRL_STALL;
      if (cnt <= 2'd1) begin
        state_next = RUN;
        cnt_next   = 2'd0;
      end else begin
        cnt_next = cnt - 2'd1;
      end
    end else if (lb && (LD_BR_STALL > 1)) begin
      ctrl       = CTRL_STALL;
      state_next = HOLD;
      cnt_next   = HOLD_LOAD;
    end else if (lu || lb || mb) begin
      ctrl = CTRL_STALL;
    end else if (ID_Jump) begin
      ctrl = CTRL_JUMP;
    end
  end

  assign PC_Write    = ctrl.pc_write;
  assign IF_ID_Write = ctrl.if_id_write;
  assign IF_ID_Flush = ctrl.if_id_flush;
  assign ID_EX_Flush = ctrl.id_ex_flush;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; the reset cycle itself is never counted
  always_ff @(posedge clk) begin
    if (!reset) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (!ctrl.pc_write && (Stall_Cnt != '1)) Stall_Cnt <= Stall_Cnt + PERF_W'(1);
      if (ctrl.if_id_flush && (Flush_Cnt != '1)) Flush_Cnt <= Flush_Cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (LD_BR_STALL=2);
// counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_hazard_stall_controller;

  localparam logic [3:0] NORM = 4'b1100;
  localparam logic [3:0] STAL = 4'b0001;
  localparam logic [3:0] JUMP = 4'b1110;
  localparam logic [3:0] BRAN = 4'b1111;
  localparam logic [3:0] RSTO = 4'b0011;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, ID_EX_Write_Addr, EX_MEM_Write_Addr;
  logic       ID_Use_Rs, ID_Use_Rt, ID_Early_Rs, ID_Jump;
  logic       ID_EX_MemRead, EX_MEM_MemRead, EX_Branch_Taken;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic [3:0] outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cnt, Flush_Cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush};

  hazard_stall_controller #(.LD_BR_STALL(2), .PERF_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .ID_Rs             (ID_Rs),
    .ID_Rt             (ID_Rt),
    .ID_Use_Rs         (ID_Use_Rs),
    .ID_Use_Rt         (ID_Use_Rt),
    .ID_Early_Rs       (ID_Early_Rs),
    .ID_Jump           (ID_Jump),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_Write_Addr  (ID_EX_Write_Addr),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_Write_Addr (EX_MEM_Write_Addr),
    .EX_Branch_Taken   (EX_Branch_Taken),
    .PC_Write          (PC_Write),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Flush       (IF_ID_Flush),
    .ID_EX_Flush       (ID_EX_Flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cnt         (Stall_Cnt),
    .Flush_Cnt         (Flush_Cnt)
`endif
  );

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_Use_Rs = 1'b0; ID_Use_Rt = 1'b0;
    ID_Early_Rs = 1'b0; ID_Jump = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_Write_Addr = 5'd0; EX_MEM_MemRead = 1'b0; EX_MEM_Write_Addr = 5'd0;
    EX_Branch_Taken = 1'b0;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (outs !== RSTO) begin errors++; $display("[TB] FAIL reset_out: got %b expected %b", outs, RSTO); end
    tick();
    ID_Jump = 1'b1; EX_Branch_Taken = 1'b1; #1;
    checks++;
    if (outs !== RSTO) begin errors++; $display("[TB] FAIL reset_priority: got %b expected %b", outs, RSTO); end
    tick();
    reset = 1'b1;
    clear_inputs(); #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL reset_release: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd8; ID_Rt = 5'd8; ID_Use_Rt = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL lu_rt_stall: got %b expected %b", outs, STAL); end
    tick();
    ID_EX_MemRead = 1'b0; EX_MEM_MemRead = 1'b1; EX_MEM_Write_Addr = 5'd8; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL lu_rt_release: got %b expected %b", outs, NORM); end
    tick();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd12; ID_Rs = 5'd12; ID_Use_Rs = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL lu_rs_stall: got %b expected %b", outs, STAL); end
    ID_Use_Rs = 1'b0; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL lu_rs_unused: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_load_branch_hold();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd9; ID_Rs = 5'd9;
    ID_Early_Rs = 1'b1; ID_Jump = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL lb_stall1: got %b expected %b", outs, STAL); end
    tick();
    ID_EX_MemRead = 1'b0; ID_EX_Write_Addr = 5'd0; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL lb_hold_stall2: got %b expected %b", outs, STAL); end
    tick();
    #1;
    checks++;
    if (outs !== JUMP) begin errors++; $display("[TB] FAIL lb_jump_leaves: got %b expected %b", outs, JUMP); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL lb_after: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_zero_dest();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    ID_Early_Rs = 1'b1; ID_Use_Rs = 1'b1; ID_Use_Rt = 1'b1;
    EX_MEM_MemRead = 1'b1; EX_MEM_Write_Addr = 5'd0; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL zero_dest: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_mem_branch();
    clear_inputs();
    EX_MEM_MemRead = 1'b1; EX_MEM_Write_Addr = 5'd5; ID_Rs = 5'd5; ID_Early_Rs = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL mb_stall: got %b expected %b", outs, STAL); end
    tick();
    EX_MEM_MemRead = 1'b0; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL mb_single: got %b expected %b", outs, NORM); end
    tick();
    clear_inputs();
    EX_MEM_MemRead = 1'b1; EX_MEM_Write_Addr = 5'd5; ID_Rs = 5'd5; ID_Use_Rs = 1'b1; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL mb_late_use: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_branch_abort();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd3; ID_Rs = 5'd3; ID_Early_Rs = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL abort_enter: got %b expected %b", outs, STAL); end
    tick();
    clear_inputs();
    EX_Branch_Taken = 1'b1; #1;
    checks++;
    if (outs !== BRAN) begin errors++; $display("[TB] FAIL abort_branch: got %b expected %b", outs, BRAN); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL abort_after: got %b expected %b", outs, NORM); end
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd4; ID_Rt = 5'd4; ID_Use_Rt = 1'b1;
    EX_Branch_Taken = 1'b1; ID_Jump = 1'b1; #1;
    checks++;
    if (outs !== BRAN) begin errors++; $display("[TB] FAIL branch_over_lu: got %b expected %b", outs, BRAN); end
    tick();
  endtask

  task automatic test_reset_in_hold();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd6; ID_Rs = 5'd6; ID_Early_Rs = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL rh_enter: got %b expected %b", outs, STAL); end
    tick();
    clear_inputs();
    reset = 1'b0; #1;
    checks++;
    if (outs !== RSTO) begin errors++; $display("[TB] FAIL rh_reset_out: got %b expected %b", outs, RSTO); end
    tick();
    reset = 1'b1; #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL rh_run: got %b expected %b", outs, NORM); end
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd7; ID_Rt = 5'd7; ID_Use_Rt = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL rh_lu: got %b expected %b", outs, STAL); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL rh_lu_single: got %b expected %b", outs, NORM); end
    tick();
  endtask

  task automatic test_jump();
    clear_inputs();
    ID_Jump = 1'b1; #1;
    checks++;
    if (outs !== JUMP) begin errors++; $display("[TB] FAIL jump_plain: got %b expected %b", outs, JUMP); end
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd10; ID_Rt = 5'd10; ID_Use_Rt = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL jump_vs_stall: got %b expected %b", outs, STAL); end
    tick();
  endtask

  task automatic test_lu_mb_simultaneous();
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd8; ID_Rt = 5'd8; ID_Use_Rt = 1'b1;
    EX_MEM_MemRead = 1'b1; EX_MEM_Write_Addr = 5'd11; ID_Rs = 5'd11; ID_Early_Rs = 1'b1; #1;
    checks++;
    if (outs !== STAL) begin errors++; $display("[TB] FAIL lu_mb_stall: got %b expected %b", outs, STAL); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (outs !== NORM) begin errors++; $display("[TB] FAIL lu_mb_single: got %b expected %b", outs, NORM); end
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    clear_inputs();
    reset = 1'b0;
    tick();
    checks++;
    if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_clear: got %0d/%0d expected 0/0", Stall_Cnt, Flush_Cnt);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); tick();
      ID_EX_MemRead = 1'b1; ID_EX_Write_Addr = 5'd8; ID_Rt = 5'd8; ID_Use_Rt = 1'b1;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      clear_inputs(); tick();
      ID_Jump = 1'b1;
      tick();
    end
    clear_inputs(); tick();
    checks++;
    if (Stall_Cnt !== 32'd3) begin errors++; $display("[TB] FAIL perf_stall_cnt: got %0d expected 3", Stall_Cnt); end
    checks++;
    if (Flush_Cnt !== 32'd2) begin errors++; $display("[TB] FAIL perf_flush_cnt: got %0d expected 2", Flush_Cnt); end
  endtask
`endif

  initial begin
    $display("[TB] hazard_stall_controller bench start");
    test_reset();
    test_load_use();
    test_load_branch_hold();
    test_zero_dest();
    test_mem_branch();
    test_branch_abort();
    test_reset_in_hold();
    test_jump();
    test_lu_mb_simultaneous();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
